commit_monitor: RTL and testbench

- Commit-side monitor directly upstream of the simulation halt/trace stage; consumes retired-instruction stream from write-back.
- Forwards committed instruction word and a0 (x10) to the halt stage one cycle later.
- Withholds ebreak until a drain window has elapsed so in-flight stores and logs settle.
- Adds cycle/instret counters and a no-commit watchdog that forces a bad-trap halt.

---
 rtl/commit_monitor.sv | 132 +++++++++++++
 tb/tb_commit_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_monitor.sv
// Commit-side monitor: forwards retired inst/a0 to the halt stage, drains ebreak, counts, watchdog.
// Optional macro COMMIT_MONITOR_TRACE_EN adds a commit/halt trace via $display.
module commit_monitor #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned DRAIN_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [31:0]     commit_inst,
    input  logic [XLEN-1:0] commit_a0,
    output logic [31:0]     sim_inst,
    output logic [XLEN-1:0] sim_r10,
    output logic            halted,
    output logic [1:0]      halt_reason,
    output logic [31:0]     halt_code,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt,
    output logic [XLEN-1:0] last_pc
);

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    localparam bit          WDOG_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] IDLE_LIMIT = WDOG_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
    localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 32'(DRAIN_CYCLES - 1) : 32'd0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] drain_cnt;
    logic [31:0] idle_cnt;
    logic        is_ebreak;

    assign is_ebreak = (commit_inst == EBREAK);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= 32'd0;
            idle_cnt    <= 32'd0;
            sim_inst    <= NOP;
            sim_r10     <= '0;
            halted      <= 1'b0;
            halt_reason <= 2'd0;
            halt_code   <= 32'd0;
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
            last_pc     <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    cycle_cnt <= cycle_cnt + 64'd1;
                    if (commit_valid) begin
                        // a commit always beats a coincident watchdog expiry
                        instret_cnt <= instret_cnt + 64'd1;
                        last_pc     <= commit_pc;
                        sim_r10     <= commit_a0;
                        idle_cnt    <= 32'd0;
                        if (is_ebreak) begin
                            sim_inst    <= NOP;
                            halt_code   <= commit_a0[31:0];
                            halt_reason <= 2'd1;
                            drain_cnt   <= DRAIN_LOAD;
                            state       <= DRAIN;
                        end else begin
                            sim_inst <= commit_inst;
                        end
                    end else begin
                        sim_inst <= NOP;
                        idle_cnt <= idle_cnt + 32'd1;
                        if (WDOG_EN && idle_cnt == IDLE_LIMIT) begin
                            halt_reason <= 2'd2;
                            halt_code   <= 32'hFFFF_FFFF;
                            halted      <= 1'b1;
                            sim_inst    <= EBREAK;
                            sim_r10     <= XLEN'(32'hFFFF_FFFF);
                            state       <= HALT;
                        end
                    end
                end
                DRAIN: begin
                    cycle_cnt <= cycle_cnt + 64'd1;
                    sim_inst  <= NOP;
                    if (drain_cnt == 32'd0) begin
                        halted   <= 1'b1;
                        sim_inst <= EBREAK;
                        sim_r10  <= XLEN'(halt_code);
                        state    <= HALT;
                    end else begin
                        drain_cnt <= drain_cnt - 32'd1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

`ifdef COMMIT_MONITOR_TRACE_EN
    logic [63:0] ipc_x1000;

    always_comb begin
        ipc_x1000 = 64'd0;
        if (cycle_cnt + 64'd1 != 64'd0)
            ipc_x1000 = (instret_cnt * 64'd1000) / (cycle_cnt + 64'd1);
    end

    always_ff @(posedge clock) begin
        if (!reset && state == RUN && commit_valid)
            $display("[%0d] %h %h %h", cycle_cnt, commit_pc, commit_inst, commit_a0);
        if (!reset && state == DRAIN && drain_cnt == 32'd0)
            $display("halt reason=%0d code=%h cycles=%0d instret=%0d ipc_x1000=%0d",
                     halt_reason, halt_code, cycle_cnt + 64'd1, instret_cnt, ipc_x1000);
        if (!reset && state == RUN && !commit_valid && WDOG_EN && idle_cnt == IDLE_LIMIT)
            $display("halt reason=2 code=ffffffff cycles=%0d instret=%0d ipc_x1000=%0d",
                     cycle_cnt + 64'd1, instret_cnt, ipc_x1000);
    end
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// Scoreboarded random bench for commit_monitor against a tick-based reference model.
module tb_commit_monitor;

    localparam int          DRAIN   = 2;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] EBREAK  = 32'h0010_0073;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        commit_valid = 1'b0;
    logic [63:0] commit_pc = '0;
    logic [31:0] commit_inst = NOP;
    logic [63:0] commit_a0 = '0;
    logic [31:0] sim_inst;
    logic [63:0] sim_r10;
    logic        halted;
    logic [1:0]  halt_reason;
    logic [31:0] halt_code;
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
    logic [63:0] last_pc;

    always #5 clock = ~clock;

    commit_monitor #(
        .XLEN(64),
        .DRAIN_CYCLES(DRAIN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .commit_valid(commit_valid),
        .commit_pc(commit_pc),
        .commit_inst(commit_inst),
        .commit_a0(commit_a0),
        .sim_inst(sim_inst),
        .sim_r10(sim_r10),
        .halted(halted),
        .halt_reason(halt_reason),
        .halt_code(halt_code),
        .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt),
        .last_pc(last_pc)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] r10;
        logic        hlt;
        logic [1:0]  reason;
        logic [31:0] code;
        logic [63:0] cyc;
        logic [63:0] ret;
        logic [63:0] pc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: halting is expressed as absolute tick deadlines.
    int          tick = 0;
    int          last_act = 0;
    int          halt_tick = 0;
    bit          draining = 0;
    exp_t        m;

    task automatic model_reset();
        m.inst = NOP; m.r10 = '0; m.hlt = 0; m.reason = 0; m.code = 0;
        m.cyc = 0; m.ret = 0; m.pc = 0;
        draining = 0;
        last_act = tick;
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [63:0] pc,
                              input logic [31:0] inst, input logic [63:0] a0);
        tick++;
        if (r) begin
            model_reset();
        end else if (!m.hlt) begin
            m.cyc = m.cyc + 64'd1;
            if (draining) begin
                m.inst = NOP;
                if (tick == halt_tick) begin
                    draining = 0;
                    m.hlt = 1;
                    m.inst = EBREAK;
                    m.r10 = {32'd0, m.code};
                end
            end else if (v) begin
                m.ret = m.ret + 64'd1;
                m.pc = pc;
                m.r10 = a0;
                last_act = tick;
                if (inst == EBREAK) begin
                    m.inst = NOP;
                    m.code = a0[31:0];
                    m.reason = 1;
                    draining = 1;
                    halt_tick = tick + DRAIN;
                end else begin
                    m.inst = inst;
                end
            end else begin
                m.inst = NOP;
                if (tick - last_act == TIMEOUT) begin
                    m.hlt = 1;
                    m.reason = 2;
                    m.code = 32'hFFFF_FFFF;
                    m.inst = EBREAK;
                    m.r10 = 64'h0000_0000_FFFF_FFFF;
                end
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input logic [63:0] pc,
                        input logic [31:0] inst, input logic [63:0] a0,
                        input bit wrap = 0);
        @(negedge clock);
        reset = r;
        commit_valid = v;
        commit_pc = pc;
        commit_inst = inst;
        commit_a0 = a0;
        if (wrap) begin
            force dut.cycle_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
            #1;
            release dut.cycle_cnt;
            m.cyc = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        model_edge(r, v, pc, inst, a0);
        sb.push_back(m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 64'h0, 32'h0, 64'h0);
    endtask

    task automatic do_reset();
        step(1, 0, 64'h0, 32'h0, 64'h0);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sim_inst", 64'(sim_inst), 64'(e.inst));
                chk("sim_r10", sim_r10, e.r10);
                chk("halted", 64'(halted), 64'(e.hlt));
                chk("halt_reason", 64'(halt_reason), 64'(e.reason));
                chk("halt_code", 64'(halt_code), 64'(e.code));
                chk("cycle_cnt", cycle_cnt, e.cyc);
                chk("instret_cnt", instret_cnt, e.ret);
                chk("last_pc", last_pc, e.pc);
            end
        end
    end

    initial begin
        int w;
        model_reset();
        do_reset();
        do_reset();
        // back-to-back commits
        step(0, 1, 64'h8000_0000, NOP, 64'h1);
        step(0, 1, 64'h8000_0004, NOP, 64'h2);
        step(0, 1, 64'h8000_0008, NOP, 64'h3);
        // ebreak with a0=0, then commits while halted are ignored
        step(0, 1, 64'h8000_000C, EBREAK, 64'h0);
        idle(3);
        step(0, 1, 64'h8000_0010, 32'h0000_0033, 64'h55);
        step(0, 1, 64'h8000_0014, EBREAK, 64'h66);
        // ebreak exit code, commits during drain ignored
        do_reset();
        step(0, 1, 64'h8000_0000, 32'h0050_0513, 64'h5);
        step(0, 1, 64'h8000_0004, EBREAK, 64'hDEAD_BEEF_0000_0007);
        step(0, 1, 64'h8000_0008, 32'h0000_0013, 64'h9);
        step(0, 1, 64'h8000_000C, EBREAK, 64'hA);
        idle(3);
        // watchdog expiry
        do_reset();
        step(0, 1, 64'h8000_0000, NOP, 64'h1);
        idle(TIMEOUT + 3);
        // commit exactly at idle==TIMEOUT-1 prevents halt
        do_reset();
        step(0, 1, 64'h8000_0000, NOP, 64'h1);
        idle(TIMEOUT - 1);
        step(0, 1, 64'h8000_0004, 32'h0010_0093, 64'h2);
        idle(4);
        // reset in first drain cycle, then a clean halt
        do_reset();
        step(0, 1, 64'h8000_0000, EBREAK, 64'h3);
        do_reset();
        idle(2);
        step(0, 1, 64'h8000_0100, EBREAK, 64'h4);
        idle(4);
        // cycle counter wrap in RUN
        do_reset();
        step(0, 1, 64'h8000_0000, NOP, 64'h1);
        step(0, 1, 64'h8000_0004, NOP, 64'h2, 1);
        step(0, 1, 64'h8000_0008, NOP, 64'h3);
        // randomized segments
        for (int s = 0; s < 8; s++) begin
            do_reset();
            for (int i = 0; i < 70; i++) begin
                int r;
                logic [31:0] ins;
                r = $urandom_range(0, 99);
                ins = $urandom;
                if (ins == EBREAK) ins = ins ^ 32'h1;
                if (r == 99)
                    do_reset();
                else if (r < ((s == 7) ? 10 : 60))
                    step(0, 1, {$urandom, $urandom}, ins, {$urandom, $urandom});
                else if (r < ((s == 7) ? 11 : 63))
                    step(0, 1, {$urandom, $urandom}, EBREAK, {$urandom, $urandom});
                else
                    idle(1);
            end
        end
        w = 0;
        while (sb.size() > 0 && w < 20) begin
            @(posedge clock);
            w++;
        end
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain_queue: %0d left expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
